// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencer for the RV32I datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB over a shared datapath and one memory port,
// decodes datapath enables and selects from the state and the latched IR,
// and counts retired instructions.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        alu_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [3:0]  alu_op,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMMI = 2'd1;
    localparam logic [1:0] B_IMMS = 2'd2;
    localparam logic [1:0] B_IMMU = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t state, state_nx;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_op, is_opimm, is_lui, is_auipc, is_lw, is_sw;
    logic       legal_op, legal_opimm, legal;
    logic [3:0] fn_op;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_ir = ^ir[24:15];

    // Instruction classification and legality check.
    always_comb begin
        is_op    = (opcode == OPC_OP);
        is_opimm = (opcode == OPC_OPIMM);
        is_lui   = (opcode == OPC_LUI);
        is_auipc = (opcode == OPC_AUIPC);
        is_lw    = (opcode == OPC_LOAD)  && (funct3 == 3'b010);
        is_sw    = (opcode == OPC_STORE) && (funct3 == 3'b010);

        legal_op = is_op && ((funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

        legal_opimm = 1'b0;
        if (is_opimm) begin
            if (funct3 == 3'b001)
                legal_opimm = (funct7 == F7_BASE);
            else if (funct3 == 3'b101)
                legal_opimm = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else
                legal_opimm = 1'b1;
        end

        legal = legal_op || legal_opimm || is_lui || is_auipc || is_lw || is_sw;
    end

    // ALU function for OP/OP-IMM; ir[30] picks SUB only for register OP.
    always_comb begin
        fn_op = OP_ADD;
        case (funct3)
            3'b000:  fn_op = (is_op && ir[30]) ? OP_SUB : OP_ADD;
            3'b001:  fn_op = OP_SLL;
            3'b010:  fn_op = OP_SLT;
            3'b011:  fn_op = OP_SLTU;
            3'b100:  fn_op = OP_XOR;
            3'b101:  fn_op = ir[30] ? OP_SRA : OP_SRL;
            3'b110:  fn_op = OP_OR;
            default: fn_op = OP_AND;
        endcase
    end

    // State register; reset also drops any outstanding request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        alu_we    = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        alu_a_sel = A_RS1;
        alu_b_sel = B_RS2;
        alu_op    = OP_ADD;
        retire    = 1'b0;
        illegal   = 1'b0;

        case (state)
            S_IDLE: begin
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nx = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                alu_we = 1'b1;
                if (is_op) begin
                    alu_op = fn_op;
                end else if (is_opimm) begin
                    alu_b_sel = B_IMMI;
                    alu_op    = fn_op;
                end else if (is_lui) begin
                    alu_a_sel = A_ZERO;
                    alu_b_sel = B_IMMU;
                end else if (is_auipc) begin
                    alu_a_sel = A_PC;
                    alu_b_sel = B_IMMU;
                end else if (is_lw) begin
                    alu_b_sel = B_IMMI;
                end else if (is_sw) begin
                    alu_b_sel = B_IMMS;
                end
                state_nx = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                if (mem_ack) begin
                    if (is_sw) begin
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        mdr_we   = 1'b1;
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = (rd != 5'd0);
                wb_sel   = is_lw;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                illegal = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret <= '0;
        else if (retire)
            instret <= instret + XLEN'(1);
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table of instructions with expected control behaviour, fed through
// a bench-side IR/memory responder; expectations are queued when an instruction
// is captured and checked when the DUT retires it.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        mem_ack;
    logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, alu_we, pc_we, rf_we, wb_sel;
    logic [1:0]  alu_a_sel, alu_b_sel;
    logic [3:0]  alu_op;
    logic        retire;
    logic [31:0] instret;
    logic        illegal;

    mc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .mdr_we    (mdr_we),
        .alu_we    (alu_we),
        .pc_we     (pc_we),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .retire    (retire),
        .instret   (instret),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int fwait;   // extra cycles before fetch ack
        int mwait;   // extra cycles before MEM ack
        int e_cyc;   // cycles from fetch start to retire, inclusive
        int e_op;
        int e_a;
        int e_b;
        int e_rf;    // cycles with rf_we
        int e_wb;    // wb_sel in the retire cycle
        int e_we;    // cycles with mem_we
        int e_addr;  // cycles with addr_sel
        int e_mdr;   // cycles with mdr_we
    } vec_t;

    vec_t tbl[$];
    vec_t prog_q[$];
    vec_t exp_q[$];
    vec_t cur;

    int n_vec = 0;
    int n_err = 0;

    bit fresh;
    bit cap_ir;
    int wcnt;
    int retired;
    int exp_instret;
    int cyc, o_alu, o_rf, o_we, o_addr, o_mdr, o_pc, o_bad, o_op, o_a, o_b;
    logic prev_req, prev_ack, prev_we, prev_as;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input int fw, input int mw,
                                input int cy, input int op, input int a, input int b,
                                input int rf, input int wb, input int we, input int ad,
                                input int md);
        vec_t v;
        v.instr = instr; v.fwait = fw; v.mwait = mw; v.e_cyc = cy;
        v.e_op = op; v.e_a = a; v.e_b = b; v.e_rf = rf; v.e_wb = wb;
        v.e_we = we; v.e_addr = ad; v.e_mdr = md;
        return v;
    endfunction

    // Observe one cycle of DUT outputs (called mid-cycle, at the falling edge).
    function automatic void monitor();
        vec_t e;
        if (rst) begin
            fresh    = 1'b1;
            prev_req = 1'b0;
            return;
        end
        cap_ir = ir_we;
        if (fresh && mem_req && !addr_sel) begin
            fresh = 1'b0;
            cyc = 0; o_alu = 0; o_rf = 0; o_we = 0; o_addr = 0; o_mdr = 0; o_pc = 0;
            o_bad = 0; o_op = -1; o_a = -1; o_b = -1;
        end
        if (!fresh) begin
            cyc++;
            if (alu_we) begin
                o_alu++;
                o_op = int'(alu_op); o_a = int'(alu_a_sel); o_b = int'(alu_b_sel);
            end else if (alu_op != 4'd0 || alu_a_sel != 2'd0 || alu_b_sel != 2'd0) begin
                o_bad++;
            end
            if (rf_we)    o_rf++;
            if (mem_we)   o_we++;
            if (addr_sel) o_addr++;
            if (mdr_we) begin
                o_mdr++;
                if (!mem_ack) o_bad++;
            end
            if (ir_we && !(mem_req && mem_ack && !addr_sel)) o_bad++;
            if (pc_we) o_pc++;
            if (pc_we != retire) o_bad++;
            if (mem_we && !mem_req) o_bad++;
            if (prev_req && !prev_ack &&
                (mem_req !== 1'b1 || mem_we !== prev_we || addr_sel !== prev_as)) o_bad++;
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty_on_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%08h cycles", e.instr), cyc, e.e_cyc);
                    chk($sformatf("%08h alu_we_cycles", e.instr), o_alu, 1);
                    chk($sformatf("%08h alu_op", e.instr), o_op, e.e_op);
                    chk($sformatf("%08h alu_a_sel", e.instr), o_a, e.e_a);
                    chk($sformatf("%08h alu_b_sel", e.instr), o_b, e.e_b);
                    chk($sformatf("%08h rf_we_cycles", e.instr), o_rf, e.e_rf);
                    chk($sformatf("%08h wb_sel", e.instr), int'(wb_sel), e.e_wb);
                    chk($sformatf("%08h mem_we_cycles", e.instr), o_we, e.e_we);
                    chk($sformatf("%08h addr_sel_cycles", e.instr), o_addr, e.e_addr);
                    chk($sformatf("%08h mdr_we_cycles", e.instr), o_mdr, e.e_mdr);
                    chk($sformatf("%08h pc_we_cycles", e.instr), o_pc, 1);
                    chk($sformatf("%08h protocol_violations", e.instr), o_bad, 0);
                end
                chk("instret_before_edge", int'(instret), exp_instret);
                exp_instret++;
                retired++;
                fresh = 1'b1;
            end
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_we  = mem_we;
        prev_as  = addr_sel;
    endfunction

    // One clock: model IR capture and memory response after the edge, then observe.
    task automatic tick();
        int w;
        @(posedge clk);
        #1;
        if (cap_ir) begin
            cap_ir = 1'b0;
            if (prog_q.size() > 0) begin
                cur = prog_q.pop_front();
                ir  = cur.instr;
                exp_q.push_back(cur);
            end
        end
        if (rst) begin
            mem_ack = 1'($urandom_range(0, 1));
        end else if (mem_req) begin
            if (!addr_sel && prog_q.size() == 0) begin
                mem_ack = 1'b0;
            end else begin
                w = addr_sel ? cur.mwait : prog_q[0].fwait;
                if (wcnt >= w) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end
        end else begin
            // Noise on mem_ack while no request is outstanding must be ignored.
            mem_ack = 1'($urandom_range(0, 1));
            wcnt    = 0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b1;
        ir = 32'h0;
        prog_q.delete();
        exp_q.delete();
        cap_ir = 1'b0;
        fresh = 1'b1;
        wcnt = 0;
        exp_instret = 0;
        #1;
        chk("reset_outputs_zero",
            int'({mem_req, mem_we, addr_sel, ir_we, mdr_we, alu_we, pc_we, rf_we, wb_sel,
                  alu_a_sel, alu_b_sel, alu_op, retire, illegal}), 0);
        chk("reset_instret", int'(instret), 0);
        repeat (2) @(posedge clk);
    endtask

    // Release reset; IDLE occupies the first cycle, FETCH the second.
    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        monitor();
        chk("idle_cycle_mem_req", int'(mem_req), 0);
        tick();
        chk("second_cycle_mem_req", int'(mem_req), 1);
        chk("second_cycle_addr_sel", int'(addr_sel), 0);
    endtask

    task automatic run(input int n);
        int target;
        int budget;
        target = retired + n;
        budget = 0;
        while (retired < target && budget < 40 * n) begin
            tick();
            budget++;
        end
        chk("retire_count_within_budget", retired, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        logic [31:0] bad_words [2];
        rst = 1'b1; ir = 32'h0; mem_ack = 1'b0; retired = 0;

        //             instr        fw mw cyc op a  b  rf wb we ad md
        tbl.push_back(mk(32'h00500093, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0)); // addi x1,x0,5
        tbl.push_back(mk(32'h40208033, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0)); // sub x0,x1,x2
        tbl.push_back(mk(32'h4010d093, 0, 0, 4, 7, 0, 1, 1, 0, 0, 0, 0)); // srai x1,x1,1
        tbl.push_back(mk(32'h0000a103, 0, 3, 8, 0, 0, 1, 1, 1, 0, 4, 1)); // lw x2,0(x1)
        tbl.push_back(mk(32'h0020a023, 0, 0, 4, 0, 0, 2, 0, 0, 1, 1, 0)); // sw x2,0(x1)
        tbl.push_back(mk(32'h00000033, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0)); // add x0,x0,x0
        tbl.push_back(mk(32'h123450b7, 0, 0, 4, 0, 2, 3, 1, 0, 0, 0, 0)); // lui
        tbl.push_back(mk(32'h00001117, 0, 0, 4, 0, 1, 3, 1, 0, 0, 0, 0)); // auipc
        tbl.push_back(mk(32'h0020b1b3, 0, 0, 4, 4, 0, 0, 1, 0, 0, 0, 0)); // sltu
        tbl.push_back(mk(32'h0010e213, 0, 0, 4, 8, 0, 1, 1, 0, 0, 0, 0)); // ori
        tbl.push_back(mk(32'h0020c2b3, 2, 0, 6, 5, 0, 0, 1, 0, 0, 0, 0)); // xor, slow fetch
        tbl.push_back(mk(32'h0020a023, 1, 2, 7, 0, 0, 2, 0, 0, 3, 3, 0)); // sw, slow both
        tbl.push_back(mk(32'h0020d333, 0, 0, 4, 6, 0, 0, 1, 0, 0, 0, 0)); // srl
        tbl.push_back(mk(32'h0020f3b3, 0, 0, 4, 9, 0, 0, 1, 0, 0, 0, 0)); // and
        tbl.push_back(mk(32'h002093b3, 0, 0, 4, 2, 0, 0, 1, 0, 0, 0, 0)); // sll
        tbl.push_back(mk(32'h0020a3b3, 0, 0, 4, 3, 0, 0, 1, 0, 0, 0, 0)); // slt
        tbl.push_back(mk(32'h00109093, 0, 0, 4, 2, 0, 1, 1, 0, 0, 0, 0)); // slli
        tbl.push_back(mk(32'h40000093, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0)); // addi imm bit30 set
        tbl.push_back(mk(32'h0000a103, 1, 0, 6, 0, 0, 1, 1, 1, 0, 1, 1)); // lw, slow fetch

        do_reset();
        foreach (tbl[i]) prog_q.push_back(tbl[i]);
        release_rst();
        run(tbl.size());
        tick();
        chk("instret_after_program", int'(instret), tbl.size());
        chk("no_illegal_in_program", int'(illegal), 0);

        // Unsupported encodings must halt and stay halted with no requests.
        bad_words[0] = 32'h0000007f;
        bad_words[1] = 32'h40109093;
        for (int j = 0; j < 2; j++) begin
            do_reset();
            prog_q.push_back(mk(bad_words[j], 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            release_rst();
            k = 0;
            while (!illegal && k < 10) begin
                tick();
                k++;
            end
            chk($sformatf("%08h halt_reached", bad_words[j]), int'(illegal), 1);
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (illegal !== 1'b1 || mem_req !== 1'b0 || retire !== 1'b0 ||
                    pc_we !== 1'b0 || alu_we !== 1'b0 || rf_we !== 1'b0) bad++;
            end
            chk($sformatf("%08h halt_hold_bad_cycles", bad_words[j]), bad, 0);
            chk($sformatf("%08h halt_instret", bad_words[j]), int'(instret), 0);
        end

        // Reset while a load waits in MEM: request must drop without a clock edge.
        do_reset();
        prog_q.push_back(mk(32'h0000a103, 0, 50, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        release_rst();
        k = 0;
        while (!(mem_req && addr_sel) && k < 20) begin
            tick();
            k++;
        end
        chk("mem_phase_reached", int'(mem_req && addr_sel), 1);
        tick();
        tick();
        chk("mem_req_held_while_waiting", int'({mem_req, addr_sel, mem_we}), 6);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_mem_req", int'(mem_req), 0);
        chk("async_reset_addr_sel", int'(addr_sel), 0);
        do_reset();
        prog_q.push_back(tbl[0]);
        release_rst();
        run(1);
        tick();
        chk("instret_after_reset_run", int'(instret), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the basic RV32I core. It sequences the shared datapath: instruction register, register file, ALU, `alu_out` and `mdr` registers, PC, and a single unified memory port, through fetch, decode, execute, memory and writeback. It reads the latched instruction word, the same field split the decoder uses, and drives every datapath enable and mux select. It also owns the memory request handshake and a retired-instruction counter.

## Interface
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ir`  in  32  instruction register contents; valid from DECODE onward.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  request is a write (SW).
- `addr_sel`  out  1  memory address mux: 0 = PC, 1 = `alu_out`.
- `ir_we`  out  1  capture memory read data into IR.
- `mdr_we`  out  1  capture memory read data into MDR.
- `alu_we`  out  1  capture ALU result into `alu_out`.
- `pc_we`  out  1  PC <= PC + 4.
- `rf_we`  out  1  register file write of `rd`.
- `wb_sel`  out  1  writeback source: 0 = `alu_out`, 1 = MDR.
- `alu_a_sel`  out  2  0 = rs1, 1 = PC, 2 = zero.
- `alu_b_sel`  out  2  0 = rs2, 1 = imm_i, 2 = imm_s, 3 = imm_u.
- `alu_op`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  32  retired instruction count.
- `illegal`  out  1  core halted on an unsupported encoding.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are decoded from the registered state and `ir`, with one exception: `ir_we`, `mdr_we`, `pc_we` and `retire` in FETCH/MEM are qualified by `mem_ack`.
- IDLE: all outputs 0; unconditionally goes to FETCH.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0. On `mem_ack`: `ir_we`=1, go to DECODE. Otherwise stay.
- DECODE: classify `ir[6:0]` and go to EXEC, or to HALT if illegal. Legal encodings:
  - OP (0110011): funct7 0000000 with any funct3, or 0100000 with funct3 000/101.
  - OP-IMM (0010011): funct3 001 requires funct7 0000000; funct3 101 requires funct7 0000000 or 0100000.
  - LUI (0110111) and AUIPC (0010111).
  - LW (0000011 with funct3 010) and SW (0100011 with funct3 010).
- EXEC: `alu_we`=1. Selects per instruction:
  - OP: a=rs1, b=rs2, op from funct3 plus `ir[30]`.
  - OP-IMM: a=rs1, b=imm_i, op from funct3; `ir[30]` is used only for funct3 101, so ADDI never becomes SUB.
  - LUI: a=zero, b=imm_u, ADD.
  - AUIPC: a=PC, b=imm_u, ADD.
  - LW: a=rs1, b=imm_i, ADD.
  - SW: a=rs1, b=imm_s, ADD.
  - Next state: MEM for LW/SW, otherwise WB.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 for SW. On `mem_ack`:
  - LW: `mdr_we`=1, go to WB.
  - SW: `pc_we`=1, `retire`=1, go to FETCH.
- WB: `rf_we`=1 only if `rd`≠0; `wb_sel`=1 for LW. `pc_we`=1, `retire`=1, go to FETCH.
- HALT: `illegal`=1, every other output 0. Terminal until `rst`.
- `alu_op`, `alu_a_sel` and `alu_b_sel` are 0 outside EXEC.
- `instret` increments on `retire` and wraps from 0xFFFFFFFF to 0 with no flag.

## Timing
- Reset: state=IDLE, `instret`=0, all outputs 0. Assertion takes effect immediately, including mid-transaction; an outstanding `mem_req` drops asynchronously.
- First `mem_req` appears in the second cycle after `rst` deasserts (IDLE lasts one cycle).
- `mem_req`, `mem_we` and `addr_sel` stay stable while waiting. `mem_ack` is ignored whenever `mem_req`=0.
- Latency with zero-wait memory (`mem_ack` in the first request cycle):
  - ALU, LUI, AUIPC: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Each wait cycle of `mem_ack` adds 1 cycle.
- The PC increments exactly once per instruction, after EXEC, so AUIPC sees the un-incremented PC.
- `instret` updates on the edge that ends the `retire` cycle.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with immediate ack:
  - `mem_req` first high in cycle 2.
  - `alu_b_sel`=1, `alu_op`=0 in EXEC.
  - `rf_we`=1 in WB; `retire` 4 cycles after fetch start; `instret`=1.
- SUB (0x40208033) then SRAI (0x4010d093):
  - SUB: `alu_op`=1.
  - SRAI: `alu_op`=7, `alu_b_sel`=1.
- LW (0x0000a103) with `mem_ack` delayed 3 cycles in MEM:
  - `addr_sel`=1 held for 4 cycles.
  - `mdr_we` coincides with the ack.
  - WB has `wb_sel`=1; total 8 cycles.
- SW (0x0020a023):
  - `mem_we`=1 only in MEM.
  - `retire` and `pc_we` on the ack; no WB; `rf_we` never 1.
- ADD with rd=x0 (0x00000033): `rf_we` stays 0; `pc_we` and `retire` still pulse.
- Illegal encoding:
  - Illegal opcode (0x0000007F): HALT, `illegal`=1 stays high with `mem_req`=0 across 10 cycles.
  - Funct7 0x20 with funct3 001: also HALT.
  - `rst` asserted mid-MEM: `mem_req` drops immediately; IDLE then FETCH.
